// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if
// Bundles the command-ROM port, the LCD_CTRL command/handshake signals and
// the sequencer status outputs. The sequencer attaches through the master
// modport. The surrounding system (CROM, LCD_CTRL, top level) attaches
// through the slave modport.
interface lcd_cmd_sequencer_if #(
  parameter int CROM_AW = 6
);
  logic               start;
  logic               CROM_rd;
  logic [CROM_AW-1:0] CROM_A;
  logic [3:0]         CROM_Q;
  logic [3:0]         cmd;
  logic               cmd_valid;
  logic               busy;
  logic               done;
  logic               seq_busy;
  logic               seq_done;
  logic               seq_err;
  logic [CROM_AW:0]   cmd_cnt;

  modport master (
    input  start, CROM_Q, busy, done,
    output CROM_rd, CROM_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, cmd_cnt
  );

  modport slave (
    output start, CROM_Q, busy, done,
    input  CROM_rd, CROM_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, cmd_cnt
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Walks a 4-bit command script held in a synchronous command ROM and hands
// each command to LCD_CTRL, one at a time, paced by LCD_CTRL busy. The script
// ends at the Write command (0). After Write, the sequencer waits for
// LCD_CTRL done and then pulses seq_done. A missing Write, or a stall longer
// than TIMEOUT cycles, ends the run with the sticky seq_err flag instead.
//
// Every output is registered. The issue decision is taken in ISSUE, and the
// cmd_valid strobe therefore appears on the following cycle. During that
// cycle the machine is already in GAP, so the strobe is never followed
// back-to-back by another one.
//
// Optional build macro: LCD_SEQ_ILLEGAL_SKIP_EN
//   defined   - opcodes 12..15 read from the ROM are skipped, not issued.
//   undefined - opcodes 12..15 are issued like any other command.
module lcd_cmd_sequencer #(
  parameter int CROM_AW = 6,
  parameter int TIMEOUT = 1024
) (
  input logic                 clk,
  input logic                 reset,
  lcd_cmd_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_INIT,
    FETCH,
    LATCH,
    ISSUE,
    GAP,
    WAIT_DONE,
    FINISH,
    ERR
  } state_t;

  localparam logic [CROM_AW-1:0] ADDR_LAST  = {CROM_AW{1'b1}};
  localparam logic [CROM_AW-1:0] ADDR_ONE   = CROM_AW'(1);
  localparam logic [CROM_AW:0]   CNT_MAX    = {1'b1, {CROM_AW{1'b0}}};
  localparam logic [CROM_AW:0]   CNT_ONE    = (CROM_AW + 1)'(1);
  localparam logic [10:0]        TIMER_LAST = 11'(TIMEOUT - 1);
  localparam logic [10:0]        TIMER_SAT  = 11'h7FF;
  localparam logic [3:0]         OP_WRITE   = 4'd0;

  state_t             state_q;
  logic [10:0]        timer_q;
  logic               CROM_rd_q;
  logic [CROM_AW-1:0] CROM_A_q;
  logic [3:0]         cmd_q;
  logic               cmd_valid_q;
  logic               seq_busy_q;
  logic               seq_done_q;
  logic               seq_err_q;
  logic [CROM_AW:0]   cmd_cnt_q;

  // Sequencer FSM with all outputs registered. The timer restarts on every state change and saturates while a state is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      CROM_rd_q   <= 1'b0;
      CROM_A_q    <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      cmd_cnt_q   <= '0;
    end else begin
      timer_q <= (timer_q == TIMER_SAT) ? timer_q : timer_q + 11'd1;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= WAIT_INIT;
            timer_q    <= '0;
            seq_busy_q <= 1'b1;
            seq_err_q  <= 1'b0;
            cmd_cnt_q  <= '0;
            CROM_A_q   <= '0;
          end
        end

        WAIT_INIT: begin
          if (!bus.busy) begin
            state_q   <= FETCH;
            timer_q   <= '0;
            CROM_rd_q <= 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            state_q   <= ERR;
            timer_q   <= '0;
            seq_err_q <= 1'b1;
          end
        end

        FETCH: begin
          state_q   <= LATCH;
          timer_q   <= '0;
          CROM_rd_q <= 1'b0;
        end

        LATCH: begin
          timer_q <= '0;
`ifdef LCD_SEQ_ILLEGAL_SKIP_EN
          if (bus.CROM_Q >= 4'd12) begin
            if (CROM_A_q == ADDR_LAST) begin
              state_q   <= ERR;
              seq_err_q <= 1'b1;
            end else begin
              state_q   <= FETCH;
              CROM_A_q  <= CROM_A_q + ADDR_ONE;
              CROM_rd_q <= 1'b1;
            end
          end else begin
            state_q <= ISSUE;
            cmd_q   <= bus.CROM_Q;
          end
`else
          state_q <= ISSUE;
          cmd_q   <= bus.CROM_Q;
`endif
        end

        ISSUE: begin
          if (!bus.busy) begin
            state_q     <= GAP;
            timer_q     <= '0;
            cmd_valid_q <= 1'b1;
            if (cmd_cnt_q != CNT_MAX) begin
              cmd_cnt_q <= cmd_cnt_q + CNT_ONE;
            end
          end
        end

        GAP: begin
          timer_q     <= '0;
          cmd_valid_q <= 1'b0;
          if (cmd_q == OP_WRITE) begin
            state_q <= WAIT_DONE;
          end else if (CROM_A_q == ADDR_LAST) begin
            state_q   <= ERR;
            seq_err_q <= 1'b1;
          end else begin
            state_q   <= FETCH;
            CROM_A_q  <= CROM_A_q + ADDR_ONE;
            CROM_rd_q <= 1'b1;
          end
        end

        WAIT_DONE: begin
          if (bus.done) begin
            state_q    <= FINISH;
            timer_q    <= '0;
            seq_done_q <= 1'b1;
          end else if (timer_q == TIMER_LAST) begin
            state_q   <= ERR;
            timer_q   <= '0;
            seq_err_q <= 1'b1;
          end
        end

        FINISH: begin
          state_q    <= IDLE;
          timer_q    <= '0;
          seq_done_q <= 1'b0;
          seq_busy_q <= 1'b0;
        end

        ERR: begin
          state_q    <= IDLE;
          timer_q    <= '0;
          seq_busy_q <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          timer_q     <= '0;
          CROM_rd_q   <= 1'b0;
          cmd_valid_q <= 1'b0;
          seq_done_q  <= 1'b0;
          seq_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CROM_rd   = CROM_rd_q;
  assign bus.CROM_A    = CROM_A_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.seq_busy  = seq_busy_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.cmd_cnt   = cmd_cnt_q;

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Command scheduler that sits in front of LCD_CTRL.
- Fetches a 4-bit command script from a synchronous command ROM (CROM) and issues each command to LCD_CTRL through cmd/cmd_valid, pacing issue with LCD_CTRL busy.
- The script terminates at the Write command (0); the block then waits for LCD_CTRL done and reports completion/error to the testbench or top level.

Parameters:
CROM_AW, 6, command ROM address width; script length limit 2**CROM_AW entries
TIMEOUT, 1024, max cycles spent in WAIT_INIT or WAIT_DONE before error

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  1-cycle pulse; begins script execution from CROM address 0
CROM_rd  output  1  CROM read enable
CROM_A  output  CROM_AW  CROM address
CROM_Q  input  4  CROM data, valid one cycle after CROM_rd/CROM_A
cmd  output  4  command to LCD_CTRL
cmd_valid  output  1  command strobe to LCD_CTRL
busy  input  1  LCD_CTRL busy
done  input  1  LCD_CTRL done pulse
seq_busy  output  1  high in every state except IDLE
seq_done  output  1  1-cycle pulse: script finished, LCD done seen
seq_err  output  1  sticky error flag, cleared by next accepted start
cmd_cnt  output  CROM_AW+1  number of commands issued since start

Behaviour:
- Reset (reset=0, async): state IDLE; CROM_rd=0, CROM_A=0, cmd=0, cmd_valid=0, seq_busy=0, seq_done=0, seq_err=0, cmd_cnt=0, timer=0. Reset mid-script aborts immediately, no further cmd_valid.
- All outputs registered.
- IDLE: start=1 -> WAIT_INIT; clear seq_err, cmd_cnt, CROM_A. start outside IDLE is ignored.
- WAIT_INIT: wait busy=0 (LCD_CTRL image load complete) -> FETCH. Timer counts; timer==TIMEOUT-1 -> ERR.
- FETCH: CROM_rd=1 for one cycle with current CROM_A -> LATCH.
- LATCH: CROM_Q captured into cmd; CROM_rd=0 -> ISSUE.
- ISSUE: when busy=0, assert cmd_valid=1 for exactly one cycle, cmd_cnt+1 -> GAP. While busy=1, hold cmd_valid=0, cmd stable.
- GAP: one mandatory cycle with cmd_valid=0 so a busy rise caused by the issued command is visible. Then:
  - issued cmd==0 -> WAIT_DONE.
  - CROM_A==2**CROM_AW-1 (script end, no Write found) -> ERR.
  - otherwise CROM_A+1 -> FETCH.
- Issue latency: 4 cycles per command minimum (FETCH, LATCH, ISSUE, GAP) when busy stays low.
- WAIT_DONE: done=1 -> FINISH. Timer==TIMEOUT-1 -> ERR. done in any other state is ignored.
- FINISH: seq_done=1 for one cycle -> IDLE.
- ERR: seq_err=1 (sticky), no cmd_valid -> IDLE next cycle. seq_done is not pulsed.
- Timer is cleared on every state entry. It is 11 bits wide and saturates.
- cmd_cnt saturates at 2**CROM_AW; it never wraps.
- Simultaneous busy fall and state entry to ISSUE: issue in that same ISSUE cycle.
- Simultaneous start and reset: reset wins.
- Opcodes 12–15 are passed through unchanged (default build).

Optional Feature:
- Macro LCD_SEQ_ILLEGAL_SKIP_EN.
- Defined: in LATCH, CROM_Q values 12–15 are not issued. Go straight to GAP-equivalent advance (CROM_A+1 -> FETCH, or ERR at script end); cmd_cnt unchanged; sticky output bit counts into seq_err? No: seq_err unaffected.
- Undefined: 12–15 are issued like any other opcode.

Test Plan:
- Script {1,4,8,0}, busy low after load, done 3 cycles after Write -> four cmd_valid pulses 4 cycles apart with cmd 1,4,8,0; cmd_cnt=4; seq_done one pulse; seq_err=0.
- Script {5,0}, LCD busy high 5 cycles after cmd 5 -> cmd 0 not issued until busy falls; exactly 2 cmd_valid pulses total.
- All 64 entries = 3 (no Write) -> 64 issues, then seq_err=1, seq_done never pulses, cmd_cnt=64.
- Script {0}, done never asserted -> seq_err=1 exactly TIMEOUT cycles after WAIT_DONE entry.
- Reset low during ISSUE of 3rd command -> cmd_valid=0 and all outputs at reset values same cycle; new start reruns from address 0.
- With LCD_SEQ_ILLEGAL_SKIP_EN: script {13,2,0} -> cmd_valid only for 2 and 0; cmd_cnt=2; without macro, 3 pulses including cmd 13.
